// File: rtl/cpu_subsys_mem_arbiter.sv
// Two-master round-robin arbiter for the CPU-subsystem memory bus, with a hung-transaction watchdog.
// Latency: one IDLE arbitration cycle, then zero added latency on the bus; one bubble between transactions.
// Backpressure: the grant is held until the slave completes, the master aborts, or the watchdog fires.
module cpu_subsys_mem_arbiter #(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              TIMEOUT   = 256,
    parameter logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic [1:0]              m_mem_valid,
    output logic [1:0]              m_mem_ready,
    input  logic [2*ADDR_W-1:0]     m_mem_addr,
    input  logic [2*DATA_W-1:0]     m_mem_wdata,
    input  logic [1:0]              m_mem_we,
    input  logic [2*(DATA_W/8)-1:0] m_mem_be,
    output logic [DATA_W-1:0]       m_mem_rdata,
    output logic                    s_mem_valid,
    input  logic                    s_mem_ready,
    output logic [ADDR_W-1:0]       s_mem_addr,
    output logic [DATA_W-1:0]       s_mem_wdata,
    output logic                    s_mem_we,
    output logic [DATA_W/8-1:0]     s_mem_be,
    input  logic [DATA_W-1:0]       s_mem_rdata,
    output logic                    gnt_id,
    output logic                    timeout_err
);

    localparam int BE_W = DATA_W / 8;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Value of the watchdog counter on the last BUSY cycle allowed before forcing completion.
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic            last_gnt;
    logic [WD_W-1:0] wd_cnt;

    logic busy;
    logic req;
    logic timeout_hit;
    logic done;

    // Granted-master request, watchdog expiry and bus muxing; mux outputs are zeroed outside BUSY.
    always_comb begin
        busy        = (state == BUSY);
        req         = gnt_id ? m_mem_valid[1] : m_mem_valid[0];
        // A slave response in the expiry cycle takes priority over the forced error completion.
        timeout_hit = busy & req & ~s_mem_ready & (TIMEOUT > 0) & (wd_cnt == WD_LAST);
        s_mem_valid = busy & req & ~timeout_hit;
        done        = s_mem_valid & s_mem_ready;

        m_mem_ready = 2'b00;
        if (done | timeout_hit) begin
            m_mem_ready = gnt_id ? 2'b10 : 2'b01;
        end
        timeout_err = timeout_hit;

        m_mem_rdata = '0;
        if (timeout_hit) begin
            m_mem_rdata = ERR_RDATA;
        end else if (busy) begin
            m_mem_rdata = s_mem_rdata;
        end

        s_mem_addr  = '0;
        s_mem_wdata = '0;
        s_mem_we    = 1'b0;
        s_mem_be    = '0;
        if (busy) begin
            s_mem_addr  = gnt_id ? m_mem_addr[ADDR_W +: ADDR_W]  : m_mem_addr[0 +: ADDR_W];
            s_mem_wdata = gnt_id ? m_mem_wdata[DATA_W +: DATA_W] : m_mem_wdata[0 +: DATA_W];
            s_mem_we    = gnt_id ? m_mem_we[1] : m_mem_we[0];
            s_mem_be    = gnt_id ? m_mem_be[BE_W +: BE_W] : m_mem_be[0 +: BE_W];
        end
    end

    // Arbitration FSM: pick a master in IDLE, hold the grant until completion, abort or timeout.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_id   <= 1'b0;
            last_gnt <= 1'b1;
            wd_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_mem_valid) begin
                        state  <= BUSY;
                        // On conflict, the master not served last wins.
                        gnt_id <= (&m_mem_valid) ? ~last_gnt : m_mem_valid[1];
                        wd_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (done | timeout_hit | ~req) begin
                        state    <= IDLE;
                        last_gnt <= gnt_id;
                        wd_cnt   <= '0;
                    end else if (TIMEOUT > 0) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_subsys_mem_arbiter.sv
// Self-checking bench for cpu_subsys_mem_arbiter: directed scenarios followed by a randomized run.
// Expectations come from a transaction-level model (owner, busy-cycle number, last served master).
// Masters and slave are driven reactively from the model, never from DUT outputs.
module tb_cpu_subsys_mem_arbiter;

    localparam int          TMO = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mv;
    logic [1:0]  m_mem_ready;
    logic [63:0] maddr;
    logic [63:0] mwdata;
    logic [1:0]  mwe;
    logic [7:0]  mbe;
    logic [31:0] m_mem_rdata;
    logic        s_mem_valid;
    logic        s_ready;
    logic [31:0] s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic        s_mem_we;
    logic [3:0]  s_mem_be;
    logic [31:0] s_rdata;
    logic        gnt_id;
    logic        timeout_err;

    always #5 sys_clk = ~sys_clk;

    cpu_subsys_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .ERR_RDATA(ERR)) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .m_mem_valid(mv),
        .m_mem_ready(m_mem_ready),
        .m_mem_addr (maddr),
        .m_mem_wdata(mwdata),
        .m_mem_we   (mwe),
        .m_mem_be   (mbe),
        .m_mem_rdata(m_mem_rdata),
        .s_mem_valid(s_mem_valid),
        .s_mem_ready(s_ready),
        .s_mem_addr (s_mem_addr),
        .s_mem_wdata(s_mem_wdata),
        .s_mem_we   (s_mem_we),
        .s_mem_be   (s_mem_be),
        .s_mem_rdata(s_rdata),
        .gnt_id     (gnt_id),
        .timeout_err(timeout_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: is a transaction owned, by whom, which busy cycle it is, who was served last.
    bit mb;
    int mo;
    int ml;
    int mage;

    // Stimulus control: outstanding requests per master, slave latency (-1 never, 0 random).
    int rem[2];
    bit rand_mode;
    int slave_lat;

    int gq[$];
    int tmo_seen;
    int tmo_at;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_rand(input int i);
        maddr[i*32 +: 32]  = $urandom;
        mwdata[i*32 +: 32] = $urandom;
        mwe[i]             = 1'($urandom);
        mbe[i*4 +: 4]      = 4'($urandom);
    endtask

    task automatic req(input int i, input logic [31:0] a, input logic [31:0] wd,
                       input logic we, input logic [3:0] be);
        maddr[i*32 +: 32]  = a;
        mwdata[i*32 +: 32] = wd;
        mwe[i]             = we;
        mbe[i*4 +: 4]      = be;
        mv[i]              = 1'b1;
        rem[i]             = 1;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        mv      = 2'b00;
        s_ready = 1'b0;
        rem     = '{0, 0};
        #1;
        chk("rst_m_mem_ready", m_mem_ready, 0);
        chk("rst_m_mem_rdata", m_mem_rdata, 0);
        chk("rst_s_mem_valid", s_mem_valid, 0);
        chk("rst_s_mem_addr",  s_mem_addr,  0);
        chk("rst_s_mem_wdata", s_mem_wdata, 0);
        chk("rst_s_mem_we",    s_mem_we,    0);
        chk("rst_s_mem_be",    s_mem_be,    0);
        chk("rst_gnt_id",      gnt_id,      0);
        chk("rst_timeout_err", timeout_err, 0);
        mb   = 1'b0;
        mo   = 0;
        ml   = 1;
        mage = 0;
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: check outputs mid-cycle, advance the model, then drive the next inputs.
    task automatic cyc();
        logic [1:0]  e_rdy;
        logic        e_sv;
        logic        e_tmo;
        logic [31:0] e_rd;
        bit          fin;
        @(negedge sys_clk);
        e_rdy = 2'b00;
        e_sv  = 1'b0;
        e_tmo = 1'b0;
        e_rd  = '0;
        fin   = 1'b0;
        if (mb) begin
            if (!mv[mo]) begin
                fin = 1'b1;
            end else if (s_ready) begin
                e_sv      = 1'b1;
                e_rdy[mo] = 1'b1;
                e_rd      = s_rdata;
                fin       = 1'b1;
            end else if (mage == TMO) begin
                e_tmo     = 1'b1;
                e_rdy[mo] = 1'b1;
                e_rd      = ERR;
                fin       = 1'b1;
            end else begin
                e_sv = 1'b1;
            end
        end
        chk("m_mem_ready", m_mem_ready, e_rdy);
        chk("s_mem_valid", s_mem_valid, e_sv);
        chk("timeout_err", timeout_err, e_tmo);
        if (e_sv) begin
            chk("s_mem_addr",  s_mem_addr,  maddr[mo*32 +: 32]);
            chk("s_mem_wdata", s_mem_wdata, mwdata[mo*32 +: 32]);
            chk("s_mem_we",    s_mem_we,    mwe[mo]);
            chk("s_mem_be",    s_mem_be,    mbe[mo*4 +: 4]);
        end
        if (|e_rdy) chk("m_mem_rdata", m_mem_rdata, e_rd);
        if (mb) chk("gnt_id", gnt_id, mo);
        if (|m_mem_ready) gq.push_back(m_mem_ready[1] ? 1 : 0);
        if (timeout_err) begin
            tmo_seen++;
            tmo_at = mage;
        end
        @(posedge sys_clk);
        #1;
        if (!mb) begin
            if (|mv) begin
                mb   = 1'b1;
                mage = 1;
                mo   = (mv == 2'b11) ? 1 - ml : (mv[1] ? 1 : 0);
            end
        end else if (fin) begin
            mb = 1'b0;
            ml = mo;
        end else begin
            mage++;
        end
        for (int i = 0; i < 2; i++) begin
            if (e_rdy[i]) begin
                if (rem[i] > 0) rem[i]--;
                if (rem[i] > 0) load_rand(i);
                else mv[i] = 1'b0;
            end else if (rand_mode) begin
                if (mv[i] && $urandom_range(0, 39) == 0) begin
                    mv[i] = 1'b0;
                end else if (!mv[i] && rem[i] > 0 && $urandom_range(0, 2) == 0) begin
                    load_rand(i);
                    mv[i] = 1'b1;
                end
            end
        end
        if (mb) begin
            if (slave_lat < 0)       s_ready = 1'b0;
            else if (slave_lat == 0) s_ready = ($urandom_range(0, 1) == 1) || (mage == TMO);
            else                     s_ready = (mage == slave_lat);
        end else begin
            s_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        s_rdata = $urandom;
    endtask

    initial begin
        rst_n     = 1'b0;
        mv        = 2'b00;
        maddr     = '0;
        mwdata    = '0;
        mwe       = 2'b00;
        mbe       = '0;
        s_ready   = 1'b0;
        s_rdata   = '0;
        rem       = '{0, 0};
        rand_mode = 1'b0;
        slave_lat = 1;
        tmo_seen  = 0;
        tmo_at    = 0;
        mb = 1'b0; mo = 0; ml = 1; mage = 0;
        repeat (2) @(posedge sys_clk);
        do_reset();
        cyc();

        // Single m0 read, slave responds on the third BUSY cycle.
        slave_lat = 3;
        req(0, 32'h4000_0010, 32'h0, 1'b0, 4'hF);
        repeat (6) cyc();
        chk("t1_grants", gq.size(), 1);
        if (gq.size() > 0) chk("t1_master", gq[0], 0);

        // Simultaneous requests from both masters, four each, from a fresh reset.
        do_reset();
        gq.delete();
        slave_lat = 2;
        load_rand(0);
        load_rand(1);
        rem = '{4, 4};
        mv  = 2'b11;
        repeat (40) cyc();
        chk("t2_grants", gq.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < gq.size()) chk("t2_order", gq[k], k % 2);
        end

        // m1 partial write while m0 idles.
        gq.delete();
        slave_lat = 1;
        req(1, 32'h8000_0004, 32'hA5A5_5A5A, 1'b1, 4'b0011);
        repeat (5) cyc();
        chk("t3_grants", gq.size(), 1);
        if (gq.size() > 0) chk("t3_master", gq[0], 1);

        // Slave never responds: watchdog fires on BUSY cycle TMO.
        tmo_seen  = 0;
        slave_lat = -1;
        req(0, 32'h4000_0020, 32'h0, 1'b0, 4'hF);
        repeat (TMO + 4) cyc();
        chk("t4_timeouts", tmo_seen, 1);
        chk("t4_cycle", tmo_at, TMO);

        // Slave responds exactly on the expiry cycle: normal completion wins.
        tmo_seen  = 0;
        gq.delete();
        slave_lat = TMO;
        req(1, 32'h8000_0100, 32'h0, 1'b0, 4'hF);
        repeat (TMO + 4) cyc();
        chk("t5_timeouts", tmo_seen, 0);
        chk("t5_grants", gq.size(), 1);

        // Asynchronous reset in the middle of a transaction, then a normal request.
        gq.delete();
        slave_lat = -1;
        req(1, 32'h8000_0200, 32'h1234_5678, 1'b1, 4'hF);
        repeat (4) cyc();
        do_reset();
        chk("t6_no_ready_on_reset", gq.size(), 0);
        slave_lat = 1;
        req(0, 32'h4000_0300, 32'h0, 1'b0, 4'hF);
        repeat (5) cyc();
        chk("t6_after_reset", gq.size(), 1);
        if (gq.size() > 0) chk("t6_master", gq[0], 0);

        // Granted master abandons its request mid-BUSY.
        gq.delete();
        slave_lat = -1;
        req(0, 32'h4000_0400, 32'h0, 1'b0, 4'hF);
        repeat (3) cyc();
        mv[0]  = 1'b0;
        rem[0] = 0;
        repeat (2) cyc();
        chk("t6_no_ready_on_abort", gq.size(), 0);
        slave_lat = 1;
        req(1, 32'h8000_0500, 32'h0, 1'b0, 4'hF);
        repeat (5) cyc();
        chk("t6_after_abort", gq.size(), 1);

        // Randomized traffic, aborts and slave latencies.
        rand_mode = 1'b1;
        slave_lat = 0;
        rem       = '{40, 40};
        repeat (500) cyc();
        rand_mode = 1'b0;
        mv        = 2'b00;
        s_ready   = 1'b0;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
